// File: rtl/alu_acc_sequencer_pkg.sv
// Shared opcodes, ALU selects and FSM states for the accumulator sequencer.
package alu_seq_pkg;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_CLEAR = 3'b101;

  localparam logic [1:0] SEL_ADD = 2'b00;
  localparam logic [1:0] SEL_SUB = 2'b01;
  localparam logic [1:0] SEL_AND = 2'b10;
  localparam logic [1:0] SEL_OR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ISSUE   = 2'b01,
    S_CAPTURE = 2'b10
  } state_t;

  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic [1:0] op_to_sel(input logic [2:0] op);
    logic [1:0] sel;
    case (op)
      OP_ADD:  sel = SEL_ADD;
      OP_SUB:  sel = SEL_SUB;
      OP_AND:  sel = SEL_AND;
      OP_OR:   sel = SEL_OR;
      default: sel = SEL_ADD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_acc_sequencer_if.sv
// Command valid/ready bus feeding the accumulator sequencer.
interface alu_acc_sequencer_if #(parameter int WIDTH = 4);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/alu_acc_sequencer.sv
// Accumulator sequencer driving an external 4-bit combinational ALU.
// Optional zero flag output enabled by ALU_ACC_ZERO_FLAG_EN.
module alu_acc_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_acc_sequencer_if.slave cmd,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_s,
  input  logic [WIDTH-1:0] alu_o,
  input  logic             alu_co,
`ifdef ALU_ACC_ZERO_FLAG_EN
  output logic             zero,
`endif
  output logic [WIDTH-1:0] acc,
  output logic             carry,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] SETTLE_M1 = 2'(SETTLE - 1);

  state_t           state_r, state_s;
  logic [1:0]       cnt_r, cnt_s;
  logic [2:0]       op_r, op_s;
  logic [WIDTH-1:0] alu_b_r, alu_b_s;
  logic [1:0]       alu_s_r, alu_s_s;
  logic [WIDTH-1:0] acc_r, acc_s;
  logic             carry_r, carry_s;
  logic             done_r, done_s;
  logic             err_r, err_s;
  logic             ready_r, ready_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    op_s    = op_r;
    alu_b_s = alu_b_r;
    alu_s_s = alu_s_r;
    acc_s   = acc_r;
    carry_s = carry_r;
    done_s  = 1'b0;
    err_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (cmd.cmd_valid && ready_r) begin
          op_s    = cmd.cmd_op;
          alu_b_s = cmd.cmd_data;
          cnt_s   = SETTLE_M1;
          if (is_alu_op(cmd.cmd_op)) begin
            alu_s_s = op_to_sel(cmd.cmd_op);
            state_s = S_ISSUE;
          end else begin
            state_s = S_CAPTURE;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (cnt_r == 2'd0) begin
          state_s = S_CAPTURE;
        end else begin
          cnt_s = cnt_r - 2'd1;
        end
      end
      S_CAPTURE: begin
        done_s  = 1'b1;
        state_s = S_IDLE;
        case (op_r)
          OP_LOAD:  acc_s = alu_b_r;
          OP_CLEAR: begin
            acc_s   = '0;
            carry_s = 1'b0;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            acc_s   = alu_o;
            carry_s = alu_co;
          end
          default:  err_s = 1'b1;
        endcase
      end
      default: state_s = S_IDLE;
    endcase
    // Ready is registered so it tracks the state we are about to enter.
    ready_s = (state_s == S_IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= 2'd0;
      op_r    <= OP_LOAD;
      alu_b_r <= '0;
      alu_s_r <= SEL_ADD;
      acc_r   <= '0;
      carry_r <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      cnt_r   <= cnt_s;
      op_r    <= op_s;
      alu_b_r <= alu_b_s;
      alu_s_r <= alu_s_s;
      acc_r   <= acc_s;
      carry_r <= carry_s;
      done_r  <= done_s;
      err_r   <= err_s;
      ready_r <= ready_s;
    end
  end

`ifdef ALU_ACC_ZERO_FLAG_EN
  logic zero_r;

  // Zero flag reflects the accumulator value written on every retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_r <= 1'b0;
    end else if (state_r == S_CAPTURE) begin
      zero_r <= (acc_s == '0);
    end else begin
      zero_r <= zero_r;
    end
  end

  assign zero = zero_r;
`endif

  assign cmd.cmd_ready = ready_r;
  assign alu_a         = acc_r;
  assign alu_b         = alu_b_r;
  assign alu_s         = alu_s_r;
  assign acc           = acc_r;
  assign carry         = carry_r;
  assign done          = done_r;
  assign err           = err_r;

endmodule
